vp_charattr_writer: RTL and testbench
=====================================

Name: vp_charattr_writer

Overview:
Encoder for the 32-bit character-attribute cell word consumed by the video pipeline's text/graphic decode stage. Accepts one character or graphic cell command from the terminal command processor and packs it into charattr words. Expands double-width/height characters into 2 or 4 part cells and writes them to text video memory through a ready/valid write port.

Parameters:
COLUMNS, 80, text columns per row
ROWS, 51, text rows
ADDR_WIDTH, 13, cell address width; address = row*COLUMNS + col

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
cmd_valid  in  1  command present
cmd_ready  out  1  high only in IDLE
cmd_gfx  in  1  0=text cell, 1=graphic cell
cmd_col  in  7  target column
cmd_row  in  6  target row
cmd_background  in  4  background colour
cmd_foreground  in  4  foreground colour
cmd_pattern  in  4  pattern, or border L/B/R/T when func=11
cmd_func  in  2  text function
cmd_underline  in  1  underline
cmd_invert  in  1  invert
cmd_blink  in  2  blink mode
cmd_size_horz  in  1  double width
cmd_size_vert  in  1  double height
cmd_charcode  in  10  character code
cmd_gfx_bits  in  20  graphic cell bits, MSB first
cmd_mosaic  in  1  graphic cell is mosaic
mem_wr_en  out  1  write request
mem_ready  in  1  memory accepts the write this cycle
mem_address  out  ADDR_WIDTH  cell address
mem_data  out  32  charattr word
done  out  1  one-cycle pulse after the last write of a command
error  out  1  one-cycle pulse for a rejected position

Behaviour:
- Reset: state IDLE. cmd_ready=1. mem_wr_en=0. mem_address=0. mem_data=0. done=0. error=0. Reset mid-write aborts the command at once, and no further writes are issued.
- Text word: [31:28] bg, [27:24] fg, [23:20] pattern, [19:18] func, [17] underline, [16] invert, [15:14] blink, [13] part_vert, [12] part_horz, [11] size_vert, [10] size_horz, [9:0] charcode.
- Graphic word: bits[31:24] are colours. {[23:14],[9:0]} = cmd_gfx_bits[19:0]. [13:10] = 1000 if mosaic, else 0100. Size is ignored, and a graphic command always writes one cell.
- Text with size_horz=0 never sets part_horz. Text with size_vert=0 never sets part_vert. This keeps text words distinct from the graphic codes 0100 and 1000.
- Accept: cmd_valid && cmd_ready. All command fields are captured in this cycle.
- Position check: if col>=COLUMNS or row>=ROWS, the command produces no write. error pulses the cycle after accept, and the block returns to IDLE.
- Part order: TL(0,0), TR(h=1), BL(v=1), BR(v=1,h=1). Parts beyond the size flags are skipped.
- Clipping: parts at col+1>=COLUMNS or row+1>=ROWS are skipped silently. Remaining parts keep their part bits.
- Address per part: (row+v)*COLUMNS + (col+h), truncated to ADDR_WIDTH.
- States: IDLE -> WRITE (part index 0..3) -> IDLE. The first mem_wr_en is asserted the cycle after accept.
- Write handshake: mem_wr_en, mem_address and mem_data stay stable until a cycle with mem_ready=1. The next part is presented the following cycle.
- done pulses in the cycle after the last accepted write. cmd_ready returns high in that same cycle.
- Back-to-back commands therefore have a minimum of parts+1 cycles per command when mem_ready is held high.
- Underline, blink, invert, func and pattern are copied unchanged into every part. The decode stage restricts underline and bottom border to the bottom part.

Optional Feature:
VP_CHARATTR_CURSOR_EN
- Enabled: adds input cmd_set_pos and outputs cursor_col(7) and cursor_row(6), both reset to 0.
- When cmd_set_pos=1, the command uses cmd_col/cmd_row. Otherwise it uses the cursor.
- After each accepted valid command, the cursor advances by 2 if size_horz, else 1. The advance happens even if parts were clipped.
- If the new column is >= COLUMNS, the cursor moves to column 0, row+1 (row+2 if size_vert). Row wraps to 0 past ROWS-1.
- On error, the cursor is unchanged.
- Disabled: none of these ports exist, and positions always come from cmd_col/cmd_row.

Decomposition:
- Shared package vp_charattr_pkg holds the bit-field offsets and widths of charattr (shared with the decode stage), GFXMODE_BITMAP=4'b0100, GFXMODE_MOSAIC=4'b1000, and the state enum.
- One natural sub-module: vp_charattr_pack, a combinational word packer (fields + part bits -> 32-bit word). The decode-stage bench can reuse it for round-trip checks.

Test Plan:
- Single text cell: col=3, row=2, bg=1, fg=15, char=0x041, mem_ready=1 -> one write, addr=163, data=0x1F000041, done pulse, no error.
- Double size: col=10, row=0, size h+v, mem_ready=1 -> writes at 10, 11, 90, 91 with [13:10]=0011, 0111, 1011, 1111; done after the 4th write.
- Clipping: double width at col=79 -> one write only, addr row*80+79, part_horz=0. Double height at row=50 -> top parts only.
- Graphic: gfx_bits=0xFFFFF, mosaic=1, fg/bg=0 -> data=0x00FFE3FF. With mosaic=0 -> data=0x00FFD3FF.
- Backpressure: mem_ready low for 5 cycles during part 1 of a double-width write -> address and data held stable, cmd_ready=0 throughout. Reset asserted mid-command -> mem_wr_en=0 the next cycle and no further writes.
- Error: col=80 -> no mem_wr_en, error pulse one cycle after accept, cmd_ready high again. With VP_CHARATTR_CURSOR_EN, the cursor is unchanged after the error and wraps (79, r) -> (0, r+1) after a normal cell.

Source files
------------

// File: rtl/vp_charattr_pkg.sv
// Shared definitions for the 32-bit charattr cell word: field offsets/widths,
// graphic mode codes, the writer state encoding and the captured command record.
// Imported by the writer, its packer and the decode stage.
package vp_charattr_pkg;

  // Text word layout (LSB offset / width)
  localparam int CA_BG_LSB     = 28;
  localparam int CA_BG_W       = 4;
  localparam int CA_FG_LSB     = 24;
  localparam int CA_FG_W       = 4;
  localparam int CA_PAT_LSB    = 20;
  localparam int CA_PAT_W      = 4;
  localparam int CA_FUNC_LSB   = 18;
  localparam int CA_FUNC_W     = 2;
  localparam int CA_UL_BIT     = 17;
  localparam int CA_INV_BIT    = 16;
  localparam int CA_BLINK_LSB  = 14;
  localparam int CA_BLINK_W    = 2;
  localparam int CA_PART_V_BIT = 13;
  localparam int CA_PART_H_BIT = 12;
  localparam int CA_SIZE_V_BIT = 11;
  localparam int CA_SIZE_H_BIT = 10;
  localparam int CA_CHAR_LSB   = 0;
  localparam int CA_CHAR_W     = 10;

  // Graphic word layout: bits split around the 4-bit mode code
  localparam int CA_GFX_HI_LSB = 14;
  localparam int CA_GFX_HI_W   = 10;
  localparam int CA_GFX_LO_LSB = 0;
  localparam int CA_GFX_LO_W   = 10;
  localparam int CA_GFXMODE_LSB = 10;
  localparam int CA_GFXMODE_W   = 4;

  // Mode codes chosen so no text word (part bit only with its size bit) can alias them
  localparam logic [3:0] GFXMODE_BITMAP = 4'b0100;
  localparam logic [3:0] GFXMODE_MOSAIC = 4'b1000;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_WRITE = 1'b1
  } state_t;

  typedef struct packed {
    logic        gfx;
    logic [6:0]  col;
    logic [5:0]  row;
    logic [3:0]  background;
    logic [3:0]  foreground;
    logic [3:0]  pattern;
    logic [1:0]  func;
    logic        underline;
    logic        invert;
    logic [1:0]  blink;
    logic        size_horz;
    logic        size_vert;
    logic [9:0]  charcode;
    logic [19:0] gfx_bits;
    logic        mosaic;
  } cmd_t;

endpackage

// File: rtl/vp_charattr_writer_if.sv
// Command and memory-write bundle of the charattr writer.
// No logic; master = command processor side, slave = writer.
// Optional cursor signals exist only with VP_CHARATTR_CURSOR_EN defined.
interface vp_charattr_writer_if #(
  parameter int ADDR_WIDTH = 13
);
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic                  cmd_gfx;
  logic [6:0]            cmd_col;
  logic [5:0]            cmd_row;
  logic [3:0]            cmd_background;
  logic [3:0]            cmd_foreground;
  logic [3:0]            cmd_pattern;
  logic [1:0]            cmd_func;
  logic                  cmd_underline;
  logic                  cmd_invert;
  logic [1:0]            cmd_blink;
  logic                  cmd_size_horz;
  logic                  cmd_size_vert;
  logic [9:0]            cmd_charcode;
  logic [19:0]           cmd_gfx_bits;
  logic                  cmd_mosaic;
  logic                  mem_wr_en;
  logic                  mem_ready;
  logic [ADDR_WIDTH-1:0] mem_address;
  logic [31:0]           mem_data;
  logic                  done;
  logic                  error;
`ifdef VP_CHARATTR_CURSOR_EN
  logic                  cmd_set_pos;
  logic [6:0]            cursor_col;
  logic [5:0]            cursor_row;

  modport master (
    output cmd_valid, cmd_gfx, cmd_col, cmd_row, cmd_background, cmd_foreground,
           cmd_pattern, cmd_func, cmd_underline, cmd_invert, cmd_blink, cmd_size_horz,
           cmd_size_vert, cmd_charcode, cmd_gfx_bits, cmd_mosaic, mem_ready, cmd_set_pos,
    input  cmd_ready, mem_wr_en, mem_address, mem_data, done, error, cursor_col, cursor_row
  );
  modport slave (
    input  cmd_valid, cmd_gfx, cmd_col, cmd_row, cmd_background, cmd_foreground,
           cmd_pattern, cmd_func, cmd_underline, cmd_invert, cmd_blink, cmd_size_horz,
           cmd_size_vert, cmd_charcode, cmd_gfx_bits, cmd_mosaic, mem_ready, cmd_set_pos,
    output cmd_ready, mem_wr_en, mem_address, mem_data, done, error, cursor_col, cursor_row
  );
`else
  modport master (
    output cmd_valid, cmd_gfx, cmd_col, cmd_row, cmd_background, cmd_foreground,
           cmd_pattern, cmd_func, cmd_underline, cmd_invert, cmd_blink, cmd_size_horz,
           cmd_size_vert, cmd_charcode, cmd_gfx_bits, cmd_mosaic, mem_ready,
    input  cmd_ready, mem_wr_en, mem_address, mem_data, done, error
  );
  modport slave (
    input  cmd_valid, cmd_gfx, cmd_col, cmd_row, cmd_background, cmd_foreground,
           cmd_pattern, cmd_func, cmd_underline, cmd_invert, cmd_blink, cmd_size_horz,
           cmd_size_vert, cmd_charcode, cmd_gfx_bits, cmd_mosaic, mem_ready,
    output cmd_ready, mem_wr_en, mem_address, mem_data, done, error
  );
`endif
endinterface

// File: rtl/vp_charattr_pack.sv
// Packs command fields plus part bits into one 32-bit charattr word.
// Latency: purely combinational, zero cycles.
// Backpressure: none (no handshake).
module vp_charattr_pack
  import vp_charattr_pkg::*;
(
  input  cmd_t        cmd,
  input  logic        part_vert,
  input  logic        part_horz,
  output logic [31:0] word
);

  // Colours are common; the low 24 bits depend on text vs graphic cell
  always_comb begin
    word = '0;
    word[CA_BG_LSB +: CA_BG_W] = cmd.background;
    word[CA_FG_LSB +: CA_FG_W] = cmd.foreground;
    if (cmd.gfx) begin
      word[CA_GFX_HI_LSB +: CA_GFX_HI_W]   = cmd.gfx_bits[19:10];
      word[CA_GFX_LO_LSB +: CA_GFX_LO_W]   = cmd.gfx_bits[9:0];
      word[CA_GFXMODE_LSB +: CA_GFXMODE_W] = cmd.mosaic ? GFXMODE_MOSAIC : GFXMODE_BITMAP;
    end else begin
      word[CA_PAT_LSB +: CA_PAT_W]     = cmd.pattern;
      word[CA_FUNC_LSB +: CA_FUNC_W]   = cmd.func;
      word[CA_UL_BIT]                  = cmd.underline;
      word[CA_INV_BIT]                 = cmd.invert;
      word[CA_BLINK_LSB +: CA_BLINK_W] = cmd.blink;
      // A part bit is only meaningful together with its size bit
      word[CA_PART_V_BIT]              = part_vert & cmd.size_vert;
      word[CA_PART_H_BIT]              = part_horz & cmd.size_horz;
      word[CA_SIZE_V_BIT]              = cmd.size_vert;
      word[CA_SIZE_H_BIT]              = cmd.size_horz;
      word[CA_CHAR_LSB +: CA_CHAR_W]   = cmd.charcode;
    end
  end

endmodule

// File: rtl/vp_charattr_writer.sv
// Expands one text/graphic cell command into 1..4 charattr writes (optional cursor: VP_CHARATTR_CURSOR_EN).
// Latency: first write the cycle after accept; done one cycle after the last accepted write.
// Backpressure: write held stable until mem_ready; cmd_ready low for the whole command.
module vp_charattr_writer
  import vp_charattr_pkg::*;
#(
  parameter int COLUMNS    = 80,
  parameter int ROWS       = 51,
  parameter int ADDR_WIDTH = 13
) (
  input  logic               clk,
  input  logic               reset,
  vp_charattr_writer_if.slave bus
);

  state_t                state_q, state_d;
  cmd_t                  cmd_q, in_cmd, src_cmd;
  logic [1:0]            part_q, part_d, nxt_part, src_part;
  logic                  has_next;
  logic                  wr_en_q, wr_en_d, done_q, done_d, error_q, error_d;
  logic                  load_cmd, accept, pos_ok;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d, addr_next;
  logic [31:0]           data_q, data_d, word;
  logic [6:0]            pos_col;
  logic [5:0]            pos_row;

  // A part exists if its size flag is set and it does not fall off the screen
  function automatic logic part_ok(cmd_t c, logic [1:0] p);
    logic ok;
    ok = 1'b1;
    if (c.gfx && p != 2'd0) ok = 1'b0;
    if (p[0] && (!c.size_horz || int'(c.col) + 1 >= COLUMNS)) ok = 1'b0;
    if (p[1] && (!c.size_vert || int'(c.row) + 1 >= ROWS)) ok = 1'b0;
    return ok;
  endfunction

  assign accept        = bus.cmd_valid && (state_q == ST_IDLE);
  assign bus.cmd_ready = (state_q == ST_IDLE);
  assign bus.mem_wr_en = wr_en_q;
  assign bus.mem_address = addr_q;
  assign bus.mem_data  = data_q;
  assign bus.done      = done_q;
  assign bus.error     = error_q;

`ifdef VP_CHARATTR_CURSOR_EN
  logic [6:0] cursor_col_q, adv_col;
  logic [5:0] cursor_row_q, adv_row;

  assign pos_col        = bus.cmd_set_pos ? bus.cmd_col : cursor_col_q;
  assign pos_row        = bus.cmd_set_pos ? bus.cmd_row : cursor_row_q;
  assign bus.cursor_col = cursor_col_q;
  assign bus.cursor_row = cursor_row_q;

  // Cursor advance; a graphic cell is single-size so it always steps by one
  always_comb begin
    int ncol, nrow;
    ncol = int'(pos_col) + ((!bus.cmd_gfx && bus.cmd_size_horz) ? 2 : 1);
    nrow = int'(pos_row);
    if (ncol >= COLUMNS) begin
      ncol = 0;
      nrow = nrow + ((!bus.cmd_gfx && bus.cmd_size_vert) ? 2 : 1);
      if (nrow >= ROWS) nrow = 0;
    end
    adv_col = 7'(ncol);
    adv_row = 6'(nrow);
  end

  // Cursor moves on every accepted in-range command, even when parts were clipped
  always_ff @(posedge clk) begin
    if (reset) begin
      cursor_col_q <= '0;
      cursor_row_q <= '0;
    end else if (accept && pos_ok) begin
      cursor_col_q <= adv_col;
      cursor_row_q <= adv_row;
    end
  end
`else
  assign pos_col = bus.cmd_col;
  assign pos_row = bus.cmd_row;
`endif

  // Incoming command record with the resolved position
  always_comb begin
    in_cmd            = '0;
    in_cmd.gfx        = bus.cmd_gfx;
    in_cmd.col        = pos_col;
    in_cmd.row        = pos_row;
    in_cmd.background = bus.cmd_background;
    in_cmd.foreground = bus.cmd_foreground;
    in_cmd.pattern    = bus.cmd_pattern;
    in_cmd.func       = bus.cmd_func;
    in_cmd.underline  = bus.cmd_underline;
    in_cmd.invert     = bus.cmd_invert;
    in_cmd.blink      = bus.cmd_blink;
    in_cmd.size_horz  = bus.cmd_size_horz;
    in_cmd.size_vert  = bus.cmd_size_vert;
    in_cmd.charcode   = bus.cmd_charcode;
    in_cmd.gfx_bits   = bus.cmd_gfx_bits;
    in_cmd.mosaic     = bus.cmd_mosaic;
    pos_ok = (int'(pos_col) < COLUMNS) && (int'(pos_row) < ROWS);
  end

  // Find the next surviving part after the current one, in TL,TR,BL,BR order
  always_comb begin
    has_next = 1'b0;
    nxt_part = part_q;
    for (int i = 1; i < 4; i++) begin
      if (!has_next && 2'(i) > part_q && part_ok(cmd_q, 2'(i))) begin
        has_next = 1'b1;
        nxt_part = 2'(i);
      end
    end
    src_cmd   = accept ? in_cmd : cmd_q;
    src_part  = accept ? 2'd0 : nxt_part;
    addr_next = ADDR_WIDTH'((int'(src_cmd.row) + int'(src_part[1])) * COLUMNS
                            + int'(src_cmd.col) + int'(src_part[0]));
  end

  vp_charattr_pack u_pack (
    .cmd       (src_cmd),
    .part_vert (src_part[1]),
    .part_horz (src_part[0]),
    .word      (word)
  );

  // Next-state and write-port decisions
  always_comb begin
    state_d  = state_q;
    part_d   = part_q;
    wr_en_d  = wr_en_q;
    addr_d   = addr_q;
    data_d   = data_q;
    done_d   = 1'b0;
    error_d  = 1'b0;
    load_cmd = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (pos_ok) begin
            load_cmd = 1'b1;
            state_d  = ST_WRITE;
            part_d   = 2'd0;
            wr_en_d  = 1'b1;
            addr_d   = addr_next;
            data_d   = word;
          end else begin
            error_d = 1'b1;
          end
        end
      end
      ST_WRITE: begin
        if (bus.mem_ready) begin
          if (has_next) begin
            part_d = nxt_part;
            addr_d = addr_next;
            data_d = word;
          end else begin
            state_d = ST_IDLE;
            wr_en_d = 1'b0;
            done_d  = 1'b1;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        wr_en_d = 1'b0;
      end
    endcase
  end

  // State and write-port registers; reset drops any command in flight
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      part_q  <= 2'd0;
      wr_en_q <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      done_q  <= 1'b0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      part_q  <= part_d;
      wr_en_q <= wr_en_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      done_q  <= done_d;
      error_q <= error_d;
    end
  end

  // Command fields captured on accept for the later parts
  always_ff @(posedge clk) begin
    if (reset) cmd_q <= '0;
    else if (load_cmd) cmd_q <= in_cmd;
  end

endmodule

// File: tb/tb_vp_charattr_writer.sv
// Bench for vp_charattr_writer: table vectors, hand-written stall/reset sequences
// and randomized commands checked against a write-list model.
module tb_vp_charattr_writer;

  localparam int COLS = 80;
  localparam int NROWS = 51;

  typedef struct {
    logic        gfx;
    int          col;
    int          row;
    logic [3:0]  bg, fg, pat;
    logic [1:0]  func;
    logic        ul, inv;
    logic [1:0]  blink;
    logic        sh, sv;
    logic [9:0]  ch;
    logic [19:0] gb;
    logic        mosaic;
  } tcmd_t;

  typedef struct {
    tcmd_t       c;
    int          exp_n;
    logic        exp_err;
    logic [12:0] exp_a0;
    logic [31:0] exp_d0;
  } vec_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int checks = 0;
  int errors = 0;

  logic [12:0] exp_a[$];
  logic [31:0] exp_d[$];
  logic        exp_err;

  vp_charattr_writer_if #(.ADDR_WIDTH(13)) bus ();

  vp_charattr_writer #(.COLUMNS(80), .ROWS(51), .ADDR_WIDTH(13)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic tcmd_t txt(int col, int row, logic [3:0] bg, logic [3:0] fg,
                                logic [9:0] ch, logic sh, logic sv);
    tcmd_t c;
    c = '{default: '0};
    c.col = col; c.row = row; c.bg = bg; c.fg = fg; c.ch = ch; c.sh = sh; c.sv = sv;
    return c;
  endfunction

  function automatic tcmd_t gfxc(int col, int row, logic [19:0] gb, logic mosaic);
    tcmd_t c;
    c = '{default: '0};
    c.gfx = 1'b1; c.col = col; c.row = row; c.gb = gb; c.mosaic = mosaic;
    c.sh = 1'b1; c.sv = 1'b1;  // size must be ignored for graphic cells
    return c;
  endfunction

  // Expected write list straight from the cell-word and part rules
  function automatic void model(input tcmd_t c);
    logic [31:0] w;
    exp_a.delete();
    exp_d.delete();
    exp_err = (c.col >= COLS) || (c.row >= NROWS);
    if (!exp_err) begin
      if (c.gfx) begin
        w = (32'(c.bg) << 28) | (32'(c.fg) << 24) | (32'(c.gb[19:10]) << 14)
            | ((c.mosaic ? 32'd8 : 32'd4) << 10) | 32'(c.gb[9:0]);
        exp_a.push_back(13'(c.row * COLS + c.col));
        exp_d.push_back(w);
      end else begin
        for (int v = 0; v <= int'(c.sv); v++) begin
          for (int h = 0; h <= int'(c.sh); h++) begin
            if (c.col + h < COLS && c.row + v < NROWS) begin
              w = (32'(c.bg) << 28) | (32'(c.fg) << 24) | (32'(c.pat) << 20)
                  | (32'(c.func) << 18) | (32'(c.ul) << 17) | (32'(c.inv) << 16)
                  | (32'(c.blink) << 14) | (32'(v) << 13) | (32'(h) << 12)
                  | (32'(c.sv) << 11) | (32'(c.sh) << 10) | 32'(c.ch);
              exp_a.push_back(13'((c.row + v) * COLS + c.col + h));
              exp_d.push_back(w);
            end
          end
        end
      end
    end
  endfunction

  task automatic drive_cmd(input tcmd_t c);
    bus.cmd_gfx        = c.gfx;
    bus.cmd_col        = 7'(c.col);
    bus.cmd_row        = 6'(c.row);
    bus.cmd_background = c.bg;
    bus.cmd_foreground = c.fg;
    bus.cmd_pattern    = c.pat;
    bus.cmd_func       = c.func;
    bus.cmd_underline  = c.ul;
    bus.cmd_invert     = c.inv;
    bus.cmd_blink      = c.blink;
    bus.cmd_size_horz  = c.sh;
    bus.cmd_size_vert  = c.sv;
    bus.cmd_charcode   = c.ch;
    bus.cmd_gfx_bits   = c.gb;
    bus.cmd_mosaic     = c.mosaic;
  endtask

  // Issue one command, observe its writes with random stalls, compare against the model
  task automatic exec(input tcmd_t c, input int stall_pct, output int nwr, output logic got_err,
                      output logic [12:0] a0, output logic [31:0] d0);
    logic got_done, pend;
    logic [12:0] pa;
    logic [31:0] pd;
    int cyc;
    model(c);
    nwr = 0; got_err = 0; got_done = 0; pend = 0; a0 = '0; d0 = '0; pa = '0; pd = '0; cyc = 0;
    drive_cmd(c);
    bus.cmd_valid = 1'b1;
    chk("cmd_ready_before_accept", 32'(bus.cmd_ready), 1);
    step();
    bus.cmd_valid = 1'b0;
    while (cyc < 200 && !got_done && !got_err) begin
      bus.mem_ready = ($urandom_range(99) >= stall_pct);
      if (pend) begin
        chk("stall_hold_wr_en", 32'(bus.mem_wr_en), 1);
        chk("stall_hold_addr", 32'(bus.mem_address), 32'(pa));
        chk("stall_hold_data", bus.mem_data, pd);
      end
      if (bus.error) begin
        got_err = 1;
        chk("error_latency", cyc, 0);
        chk("cmd_ready_after_error", 32'(bus.cmd_ready), 1);
      end else if (bus.done) begin
        got_done = 1;
        chk("done_no_wr_en", 32'(bus.mem_wr_en), 0);
        chk("cmd_ready_at_done", 32'(bus.cmd_ready), 1);
        if (stall_pct == 0) chk("done_latency", cyc, exp_a.size());
      end else if (bus.mem_wr_en) begin
        chk("cmd_ready_busy", 32'(bus.cmd_ready), 0);
        if (bus.mem_ready) begin
          if (nwr == 0) begin a0 = bus.mem_address; d0 = bus.mem_data; end
          if (nwr < exp_a.size()) begin
            chk("write_addr", 32'(bus.mem_address), 32'(exp_a[nwr]));
            chk("write_data", bus.mem_data, exp_d[nwr]);
          end else begin
            chk("extra_write", 32'(nwr), 32'(exp_a.size()));
          end
          nwr++;
        end
      end
      pend = bus.mem_wr_en && !bus.mem_ready && !got_done && !got_err;
      pa = bus.mem_address;
      pd = bus.mem_data;
      if (!got_done && !got_err) begin
        step();
        cyc++;
      end
    end
    if (!got_done && !got_err) chk("command_timeout", 0, 1);
    chk("write_count", 32'(nwr), 32'(exp_a.size()));
    chk("error_flag", 32'(got_err), 32'(exp_err));
    step();
    chk("pulses_one_cycle", {30'd0, bus.done, bus.error}, 0);
  endtask

  vec_t tab[10];

  initial begin
    int n;
    logic e;
    logic [12:0] a0;
    logic [31:0] d0;
    tcmd_t c;

    bus.cmd_valid = 1'b0;
    bus.mem_ready = 1'b1;
    drive_cmd(txt(0, 0, 0, 0, 0, 0, 0));
`ifdef VP_CHARATTR_CURSOR_EN
    bus.cmd_set_pos = 1'b1;
`endif

    // Reset state
    reset = 1'b1;
    repeat (3) step();
    chk("reset_cmd_ready", 32'(bus.cmd_ready), 1);
    chk("reset_wr_en", 32'(bus.mem_wr_en), 0);
    chk("reset_addr", 32'(bus.mem_address), 0);
    chk("reset_data", bus.mem_data, 0);
    chk("reset_done_error", {30'd0, bus.done, bus.error}, 0);
    reset = 1'b0;
    step();

    // Table vectors
    tab[0] = '{txt(3, 2, 4'h1, 4'hF, 10'h041, 0, 0), 1, 1'b0, 13'd163, 32'h1F000041};
    tab[1] = '{txt(10, 0, 0, 0, 0, 1, 1), 4, 1'b0, 13'd10, 32'h00000C00};
    tab[2] = '{txt(79, 5, 0, 0, 10'h055, 1, 0), 1, 1'b0, 13'd479, 32'h00000455};
    tab[3] = '{txt(0, 50, 0, 0, 10'h07F, 1, 1), 2, 1'b0, 13'd4000, 32'h00000C7F};
    tab[4] = '{gfxc(0, 0, 20'hFFFFF, 1), 1, 1'b0, 13'd0, 32'h00FFE3FF};
    tab[5] = '{gfxc(1, 1, 20'hFFFFF, 0), 1, 1'b0, 13'd81, 32'h00FFD3FF};
    tab[6] = '{txt(80, 0, 0, 0, 0, 0, 0), 0, 1'b1, 13'd0, 32'h0};
    tab[7] = '{txt(5, 51, 0, 0, 0, 0, 0), 0, 1'b1, 13'd0, 32'h0};
    c = txt(79, 50, 4'hA, 4'h5, 10'h3FF, 0, 0);
    c.pat = 4'hC; c.func = 2'd3; c.ul = 1; c.inv = 1; c.blink = 2'd2;
    tab[8] = '{c, 1, 1'b0, 13'd4079, 32'hA5CF83FF};
    tab[9] = '{txt(79, 50, 0, 0, 0, 1, 1), 1, 1'b0, 13'd4079, 32'h00000C00};

    for (int i = 0; i < 10; i++) begin
      exec(tab[i].c, 0, n, e, a0, d0);
      chk($sformatf("tab%0d_count", i), 32'(n), 32'(tab[i].exp_n));
      chk($sformatf("tab%0d_error", i), 32'(e), 32'(tab[i].exp_err));
      if (tab[i].exp_n > 0) begin
        chk($sformatf("tab%0d_addr0", i), 32'(a0), 32'(tab[i].exp_a0));
        chk($sformatf("tab%0d_data0", i), d0, tab[i].exp_d0);
      end
    end

    // Backpressure: hold part 1 of a double-width cell for 5 cycles
    c = txt(20, 3, 4'h2, 4'h7, 10'h123, 1, 0);
    model(c);
    bus.mem_ready = 1'b1;
    drive_cmd(c);
    bus.cmd_valid = 1'b1;
    step();
    bus.cmd_valid = 1'b0;
    chk("bp_part0_addr", 32'(bus.mem_address), 32'(exp_a[0]));
    step();
    bus.mem_ready = 1'b0;
    chk("bp_part1_addr", 32'(bus.mem_address), 32'(exp_a[1]));
    chk("bp_part1_data", bus.mem_data, exp_d[1]);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("bp_hold_wr_en", 32'(bus.mem_wr_en), 1);
      chk("bp_hold_addr", 32'(bus.mem_address), 32'(exp_a[1]));
      chk("bp_hold_data", bus.mem_data, exp_d[1]);
      chk("bp_cmd_ready_low", 32'(bus.cmd_ready), 0);
    end
    bus.mem_ready = 1'b1;
    step();
    chk("bp_done", 32'(bus.done), 1);
    chk("bp_wr_en_off", 32'(bus.mem_wr_en), 0);
    step();

    // Reset in the middle of a stalled 4-part command
    c = txt(10, 10, 4'h3, 4'h4, 10'h055, 1, 1);
    bus.mem_ready = 1'b0;
    drive_cmd(c);
    bus.cmd_valid = 1'b1;
    step();
    bus.cmd_valid = 1'b0;
    step();
    chk("rst_mid_wr_en_before", 32'(bus.mem_wr_en), 1);
    reset = 1'b1;
    step();
    chk("rst_mid_wr_en", 32'(bus.mem_wr_en), 0);
    chk("rst_mid_cmd_ready", 32'(bus.cmd_ready), 1);
    chk("rst_mid_addr", 32'(bus.mem_address), 0);
    reset = 1'b0;
    bus.mem_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
      chk("rst_no_more_writes", {30'd0, bus.mem_wr_en, bus.done}, 0);
    end

    // Randomized commands against the model
    for (int i = 0; i < 300; i++) begin
      c = '{default: '0};
      c.gfx = ($urandom_range(0, 4) == 0);
      c.col = ($urandom_range(0, 1) == 1) ? int'($urandom_range(74, 82)) : int'($urandom_range(0, 79));
      c.row = ($urandom_range(0, 1) == 1) ? int'($urandom_range(47, 53)) : int'($urandom_range(0, 50));
      c.bg = 4'($urandom); c.fg = 4'($urandom); c.pat = 4'($urandom);
      c.func = 2'($urandom); c.ul = 1'($urandom); c.inv = 1'($urandom);
      c.blink = 2'($urandom); c.sh = 1'($urandom); c.sv = 1'($urandom);
      c.ch = 10'($urandom); c.gb = 20'($urandom); c.mosaic = 1'($urandom);
      exec(c, (i % 2 == 0) ? 0 : 35, n, e, a0, d0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
